// File: rtl/lcd_panel_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_panel_sequencer_if                                     |
// | Description : Bundle between the panel on/off control plus sync         |
// |               generator (master side) and the power/enable sequencer     |
// |               (slave side).                                              |
// | Signals     : on_req, hcount_reg[9:0], Vcount_reg[8:0], bl_level[7:0]    |
// |               (master -> slave); lcd_pwr_en, en_sync, disp_en, bl_en,    |
// |               panel_ready, busy, state_dbg[2:0] (slave -> master)        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface lcd_panel_sequencer_if;
    logic       on_req;
    logic [9:0] hcount_reg;
    logic [8:0] Vcount_reg;
    logic [7:0] bl_level;
    logic       lcd_pwr_en;
    logic       en_sync;
    logic       disp_en;
    logic       bl_en;
    logic       panel_ready;
    logic       busy;
    logic [2:0] state_dbg;

    modport master (
        output on_req, hcount_reg, Vcount_reg, bl_level,
        input  lcd_pwr_en, en_sync, disp_en, bl_en, panel_ready, busy, state_dbg
    );

    modport slave (
        input  on_req, hcount_reg, Vcount_reg, bl_level,
        output lcd_pwr_en, en_sync, disp_en, bl_en, panel_ready, busy, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/lcd_panel_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_panel_sequencer                                        |
// | Description : Power/enable sequencer for the 480x272 LCD timing path.    |
// |               Raises panel power, sync run enable, DISP and backlight in |
// |               panel order and drops them in reverse; frame-based steps   |
// |               land on frame boundaries seen on hcount_reg/Vcount_reg.    |
// | Ports       : clk_lcd  pixel clock, all logic on posedge                 |
// |               rst      synchronous active-high reset                     |
// |               bus      lcd_panel_sequencer_if.slave (control + status)   |
// | Option      : LCD_BL_PWM_EN - backlight driven by 8-bit PWM of bl_level  |
// |               in RUN; undefined - bl_en is a plain level in RUN.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lcd_panel_sequencer #(
    parameter int PWR_DLY     = 1000,
    parameter int SYNC_FRAMES = 2,
    parameter int OFF_FRAMES  = 2,
    parameter int H_LAST      = 479,
    parameter int V_LAST      = 271
) (
    input wire                    clk_lcd,
    input wire                    rst,
    lcd_panel_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_PWR_UP     = 3'd1,
        ST_SYNC_START = 3'd2,
        ST_DISP_ON    = 3'd3,
        ST_RUN        = 3'd4,
        ST_BL_OFF     = 3'd5,
        ST_DISP_OFF   = 3'd6,
        ST_PWR_DOWN   = 3'd7
    } state_t;

    localparam int c_cnt_max =
        (PWR_DLY >= SYNC_FRAMES && PWR_DLY >= OFF_FRAMES) ? PWR_DLY :
        (SYNC_FRAMES >= OFF_FRAMES) ? SYNC_FRAMES : OFF_FRAMES;
    localparam int c_cnt_w = $clog2(c_cnt_max + 1);

    // A step completes on the event that brings the count to its target, so
    // the comparison is against target-1 of the current count.
    localparam logic [c_cnt_w-1:0] c_pwr_last  = c_cnt_w'(PWR_DLY - 1);
    localparam logic [c_cnt_w-1:0] c_sync_last = c_cnt_w'(SYNC_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_off_last  = c_cnt_w'(OFF_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [9:0]         c_h_last    = 10'(H_LAST);
    localparam logic [8:0]         c_v_last    = 9'(V_LAST);

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 fe_cond_q;
    logic                 lcd_pwr_en_q, en_sync_q, disp_en_q, bl_en_q;
    logic                 panel_ready_q, busy_q;
    logic [2:0]           state_dbg_q;
    logic                 w_fe_cond, w_frame_end, w_bl_on;

    // Frame end is qualified by our own en_sync so a stopped generator can
    // never advance the frame counts.
    assign w_fe_cond   = en_sync_q && (bus.hcount_reg == c_h_last) && (bus.Vcount_reg == c_v_last);
    assign w_frame_end = w_fe_cond && !fe_cond_q;

`ifdef LCD_BL_PWM_EN
    logic [7:0] pwm_cnt_q;
    assign w_bl_on = (state_q == ST_RUN) && (pwm_cnt_q < bus.bl_level);
`else
    logic w_bl_level_unused;
    assign w_bl_level_unused = ^bus.bl_level;
    assign w_bl_on = (state_q == ST_RUN);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (bus.on_req) state_d = ST_PWR_UP;
            end
            ST_PWR_UP: begin
                // Abort is checked first so power-off ordering always wins.
                if (!bus.on_req)               state_d = ST_PWR_DOWN;
                else if (cnt_q == c_pwr_last)  state_d = ST_SYNC_START;
                else                           cnt_d   = cnt_q + c_cnt_one;
            end
            ST_SYNC_START: begin
                if (!bus.on_req) state_d = ST_PWR_DOWN;
                else if (w_frame_end) begin
                    if (cnt_q == c_sync_last) state_d = ST_DISP_ON;
                    else                      cnt_d   = cnt_q + c_cnt_one;
                end
            end
            ST_DISP_ON: begin
                if (!bus.on_req)      state_d = ST_DISP_OFF;
                else if (w_frame_end) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.on_req) state_d = ST_BL_OFF;
            end
            // Shutdown states run to completion regardless of on_req.
            ST_BL_OFF: begin
                if (w_frame_end) state_d = ST_DISP_OFF;
            end
            ST_DISP_OFF: begin
                if (w_frame_end) begin
                    if (cnt_q == c_off_last) state_d = ST_PWR_DOWN;
                    else                     cnt_d   = cnt_q + c_cnt_one;
                end
            end
            ST_PWR_DOWN: begin
                if (cnt_q == c_pwr_last) state_d = ST_OFF;
                else                     cnt_d   = cnt_q + c_cnt_one;
            end
            default: state_d = ST_OFF;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk_lcd) begin
        if (rst) begin
            state_q       <= ST_OFF;
            cnt_q         <= '0;
            fe_cond_q     <= 1'b0;
            lcd_pwr_en_q  <= 1'b0;
            en_sync_q     <= 1'b0;
            disp_en_q     <= 1'b0;
            bl_en_q       <= 1'b0;
            panel_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            state_dbg_q   <= 3'd0;
`ifdef LCD_BL_PWM_EN
            pwm_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fe_cond_q     <= w_fe_cond;
            // Outputs follow the current state, one cycle behind it.
            lcd_pwr_en_q  <= (state_q != ST_OFF);
            en_sync_q     <= (state_q == ST_SYNC_START) || (state_q == ST_DISP_ON) ||
                             (state_q == ST_RUN) || (state_q == ST_BL_OFF) ||
                             (state_q == ST_DISP_OFF);
            disp_en_q     <= (state_q == ST_DISP_ON) || (state_q == ST_RUN) ||
                             (state_q == ST_BL_OFF);
            bl_en_q       <= w_bl_on;
            panel_ready_q <= (state_q == ST_RUN);
            busy_q        <= (state_q != ST_OFF) && (state_q != ST_RUN);
            state_dbg_q   <= state_q;
`ifdef LCD_BL_PWM_EN
            pwm_cnt_q     <= pwm_cnt_q + 8'd1;
`endif
        end
    end

    assign bus.lcd_pwr_en  = lcd_pwr_en_q;
    assign bus.en_sync     = en_sync_q;
    assign bus.disp_en     = disp_en_q;
    assign bus.bl_en       = bl_en_q;
    assign bus.panel_ready = panel_ready_q;
    assign bus.busy        = busy_q;
    assign bus.state_dbg   = state_dbg_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_panel_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lcd_panel_sequencer                                     |
// | Description : Directed self-checking bench for lcd_panel_sequencer with  |
// |               PWR_DLY=4, SYNC_FRAMES=2, OFF_FRAMES=1, 8x4 frames.        |
// |               Outputs lag the state by one cycle, so an input applied    |
// |               before edge N shows on the outputs after edge N+1.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lcd_panel_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef LCD_BL_PWM_EN
    localparam logic c_bl_run = 1'b0;   // bl_level held at 0 outside the PWM test
`else
    localparam logic c_bl_run = 1'b1;
`endif

    lcd_panel_sequencer_if bus_if ();

    lcd_panel_sequencer #(
        .PWR_DLY     (4),
        .SYNC_FRAMES (2),
        .OFF_FRAMES  (1),
        .H_LAST      (7),
        .V_LAST      (3)
    ) dut (
        .clk_lcd (clk),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // Sync generator model: counts while en_sync is high, parked at 0 otherwise.
    logic [9:0] r_h = 10'd0;
    logic [8:0] r_v = 9'd0;
    always @(posedge clk) begin
        if (!bus_if.en_sync) begin
            r_h <= 10'd0;
            r_v <= 9'd0;
        end else if (r_h == 10'd7) begin
            r_h <= 10'd0;
            r_v <= (r_v == 9'd3) ? 9'd0 : r_v + 9'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end
    assign bus_if.hcount_reg = r_h;
    assign bus_if.Vcount_reg = r_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Packed {pwr,sync,disp,bl,ready,busy,state_dbg}
    task automatic chk_st(input string tag, input logic pwr, input logic syn, input logic disp,
                          input logic bl, input logic rdy, input logic bsy, input logic [2:0] dbg);
        chk(tag,
            32'({bus_if.lcd_pwr_en, bus_if.en_sync, bus_if.disp_en, bus_if.bl_en,
                 bus_if.panel_ready, bus_if.busy, bus_if.state_dbg}),
            32'({pwr, syn, disp, bl, rdy, bsy, dbg}));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Entered from OFF with en_sync low; ends with RUN visible on the outputs.
    task automatic power_up();
        bus_if.on_req = 1'b1;
        step(1);  chk_st("pu_e1",   0,0,0,0,0,0,3'd0);
        step(1);  chk_st("pu_pwr",  1,0,0,0,0,1,3'd1);
        step(3);  chk_st("pu_e5",   1,0,0,0,0,1,3'd1);
        step(1);  chk_st("pu_sync", 1,1,0,0,0,1,3'd2);
        step(64); chk_st("pu_e70",  1,1,0,0,0,1,3'd2);
        step(1);  chk_st("pu_disp", 1,1,1,0,0,1,3'd3);
        step(31); chk_st("pu_e102", 1,1,1,0,0,1,3'd3);
        step(1);  chk_st("pu_run",  1,1,1,c_bl_run,1,0,3'd4);
    endtask

    // Entered right after power_up; rereq raises on_req again during DISP_OFF.
    task automatic power_down(input bit rereq);
        bus_if.on_req = 1'b0;
        step(1);  chk_st("pd_e1",   1,1,1,c_bl_run,1,0,3'd4);
        step(1);  chk_st("pd_bl",   1,1,1,0,0,1,3'd5);
        step(29); chk_st("pd_e134", 1,1,1,0,0,1,3'd5);
        step(1);  chk_st("pd_disp", 1,1,0,0,0,1,3'd6);
        if (rereq) bus_if.on_req = 1'b1;
        step(31); chk_st("pd_e166", 1,1,0,0,0,1,3'd6);
        step(1);  chk_st("pd_sync", 1,0,0,0,0,1,3'd7);
        step(3);  chk_st("pd_e170", 1,0,0,0,0,1,3'd7);
        step(1);  chk_st("pd_off",  0,0,0,0,0,0,3'd0);
    endtask

    initial begin
        bus_if.on_req   = 1'b0;
        bus_if.bl_level = 8'd0;

        step(2);
        chk_st("reset", 0,0,0,0,0,0,3'd0);
        rst = 1'b0;

        power_up();
        power_down(1'b0);

        // Abort after one frame end in SYNC_START: DISP never raised.
        bus_if.on_req = 1'b1;
        step(38); chk_st("ab_fe1",  1,1,0,0,0,1,3'd2);
        step(2);
        bus_if.on_req = 1'b0;
        step(1);  chk_st("ab_e41",  1,1,0,0,0,1,3'd2);
        step(1);  chk_st("ab_pd",   1,0,0,0,0,1,3'd7);
        step(3);  chk_st("ab_e45",  1,0,0,0,0,1,3'd7);
        step(1);  chk_st("ab_off",  0,0,0,0,0,0,3'd0);

        // Re-request during DISP_OFF: shutdown completes, then PWR_UP.
        power_up();
        power_down(1'b1);
        step(1);  chk_st("rr_pwrup", 1,0,0,0,0,1,3'd1);

        step(101); chk_st("t5_run", 1,1,1,c_bl_run,1,0,3'd4);

`ifdef LCD_BL_PWM_EN
        begin
            int hi;
            hi = 0;
            bus_if.bl_level = 8'd64;
            for (int i = 0; i < 256; i++) begin
                step(1);
                hi += int'(bus_if.bl_en);
            end
            chk("pwm_64", 32'(hi), 32'd64);
            hi = 0;
            bus_if.bl_level = 8'd0;
            for (int i = 0; i < 256; i++) begin
                step(1);
                hi += int'(bus_if.bl_en);
            end
            chk("pwm_0", 32'(hi), 32'd0);
        end
`endif

        // Reset mid-RUN.
        rst = 1'b1;
        step(1);  chk_st("rst_run", 0,0,0,0,0,0,3'd0);
        rst = 1'b0;

        // on_req drops in the cycle the power delay completes: abort wins.
        step(4);
        bus_if.on_req = 1'b0;
        step(1);  chk_st("pr_e5",   1,0,0,0,0,1,3'd1);
        step(1);  chk_st("pr_abort",1,0,0,0,0,1,3'd7);
        step(3);  chk_st("pr_e9",   1,0,0,0,0,1,3'd7);
        step(1);  chk_st("pr_off",  0,0,0,0,0,0,3'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
